sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
Parametrised serial-to-parallel deserialiser, successor to the basic enable-gated SIPO shifter.
- Assembles WIDTH-bit words from a bit stream qualified by a strobe, in selectable bit order.
- Presents each completed word on a one-entry valid/ready output buffer.
- Flags overruns when the consumer stalls.
- Sits between serial front-ends (SPI/UART-style receivers) and word-oriented datapaths.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..64.
ODD_PARITY, 0, parity sense (0 = even, 1 = odd); used only when PARITY_CHECK_EN is defined.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
bit_en  input  1  serial_in carries a valid bit this cycle
serial_in  input  1  serial data bit
msb_first  input  1  bit order: 1 = first bit lands in word_out[WIDTH-1], 0 = first bit lands in word_out[0]
clr  input  1  synchronous abort of the partially assembled word
word_out  output  WIDTH  assembled word, held while word_valid=1
word_valid  output  1  word_out holds an unconsumed word
word_ready  input  1  consumer accepts word when word_valid & word_ready
overrun  output  1  one-cycle pulse: completed word dropped because the buffer was occupied
bit_count  output  $clog2(WIDTH+2)  bits accepted in the current frame
parity_err  output  1  parity mismatch for the word in the buffer; tied 0 without the macro

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; shift register, bit_count, word_out = 0; word_valid, overrun, parity_err = 0.
- FSM states:
  - IDLE: bit_count=0. bit_en moves to SHIFT, latches msb_first as the frame order, and stores the bit.
  - SHIFT: each bit_en stores one bit. On the WIDTH-th bit:
    - without the macro, the frame completes and the FSM returns to IDLE;
    - with the macro, the FSM goes to PARITY.
  - PARITY (macro only): the next bit_en is the parity bit, then the frame completes and the FSM returns to IDLE.
- Bit order:
  - MSB order shifts left, inserting at bit 0; the first bit ends up at WIDTH-1.
  - LSB order shifts right, inserting at WIDTH-1; the first bit ends up at 0.
  - msb_first is sampled only on the first bit of a frame; changes mid-frame are ignored.
- Cycles with bit_en=0 hold all frame state; there is no timeout.
- Latency: the word including the final bit is transferred to the buffer on the clock edge that samples the final bit. word_valid is high in the following cycle.
- Buffer rules:
  - Pop on word_valid & word_ready.
  - A transfer succeeds if the buffer is empty, or is being popped in the same cycle (back-to-back, no bubble).
  - Otherwise the new word is discarded, word_out/word_valid are unchanged, and overrun pulses for one cycle.
- clr=1: the FSM goes to IDLE, and bit_count and the shift register are set to 0.
  - clr with bit_en in the same cycle: clr wins and the bit is dropped.
  - clr does not affect the buffer, word_valid or parity_err.
- bit_count increments per accepted bit and returns to 0 on frame completion. Maximum value is WIDTH-1, or WIDTH with the macro.
- rst_n asserted mid-frame or with word_valid=1: all state is lost immediately. No partial word is ever emitted.

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined:
  - A frame is WIDTH data bits plus 1 parity bit.
  - parity_err is loaded together with word_out: 1 iff (^data ^ parity_bit) != ODD_PARITY.
  - The word is delivered regardless of parity_err.
  - parity_err clears when the buffer is popped with no simultaneous transfer.
- Undefined:
  - A frame is WIDTH bits.
  - The PARITY state is not built.
  - parity_err is constant 0.

Decomposition:
- Package sipo_deser_pkg holds:
  - the state enum typedef (IDLE, SHIFT, PARITY);
  - constants ORDER_LSB=1'b0 and ORDER_MSB=1'b1;
  - a function for the bit_count width.
- Sub-module sipo_word_buf: one-entry valid/ready holding register with load, pop and an overrun output. It is reusable by other serial receivers.
- The FSM and shifter stay in the top module.

Test Plan:
1. WIDTH=8, msb_first=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles, word_ready=1 -> word_out=8'hA5, word_valid high 1 cycle after the 8th bit, overrun=0.
2. msb_first=0, same bit sequence -> word_out=8'hA5 reversed = 8'hA5 (palindrome check); then bits 1,1,1,1,0,0,0,0 -> 8'h0F.
3. bit_en toggled every 3rd cycle, msb_first flipped after bit 4 -> order from the first bit is kept and the result matches scenario 1.
4. word_ready=0, two full frames (8'h3C then 8'hC3) -> word_out stays 8'h3C, overrun pulses once when the 8th bit of 8'hC3 is sampled. Then word_ready=1 with a third frame 8'h81 completing in the same cycle as the pop -> 8'h81 is loaded with no bubble.
5. After 5 bits, clr=1 together with bit_en=1 -> bit_count=0. The next 8 bits form a clean word; an earlier buffered word is unaffected.
6. PARITY_CHECK_EN, ODD_PARITY=0: data 8'h07 with parity bit 1 -> parity_err=0; data 8'h07 with parity bit 0 -> parity_err=1 and word still delivered. Also assert rst_n mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sipo_deser_pkg.sv
// Shared types and helpers for the sipo_deser serial-to-parallel deserialiser.
package sipo_deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

    // bit_count must hold up to WIDTH (the parity-bit slot), so size for WIDTH+2 codes.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/sipo_word_buf.sv
// One-entry valid/ready holding register; a load into an occupied, unpopped entry is dropped and flagged.
module sipo_word_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             err_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             err_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             ovr_q, ovr_d;
    logic             pop_c;
    logic             accept_c;

    // A pop in the same cycle frees the slot, giving back-to-back transfers without a bubble.
    always_comb begin
        pop_c    = valid_q & ready_i;
        accept_c = load_i & (~valid_q | pop_c);
        data_d   = data_q;
        err_d    = err_q;
        valid_d  = valid_q & ~pop_c;
        ovr_d    = load_i & ~accept_c;
        if (accept_c) begin
            data_d  = data_i;
            err_d   = err_i;
            valid_d = 1'b1;
        end else if (pop_c) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign err_o     = err_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/sipo_deser.sv
// Strobe-qualified serial-to-parallel deserialiser with selectable bit order and a one-word output buffer.
// Define PARITY_CHECK_EN to append a parity bit to each frame and report parity_err.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           bit_en,
    input  logic                           serial_in,
    input  logic                           msb_first,
    input  logic                           clr,
    output logic [WIDTH-1:0]               word_out,
    output logic                           word_valid,
    input  logic                           word_ready,
    output logic                           overrun,
    output logic [cnt_w(WIDTH)-1:0]        bit_count,
    output logic                           parity_err
);

    localparam int unsigned     CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             order_q, order_d;
    logic             order_c;
    logic [WIDTH-1:0] shifted_c;
    logic             load_c;
    logic [WIDTH-1:0] load_word_c;
    logic             load_err_c;

    // Frame order comes from msb_first only on the first bit; afterwards the latched order rules.
    always_comb begin
        order_c   = (state_q == IDLE) ? msb_first : order_q;
        shifted_c = (order_c == ORDER_MSB) ? {shreg_q[WIDTH-2:0], serial_in}
                                           : {serial_in, shreg_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        order_d     = order_q;
        load_c      = 1'b0;
        load_word_c = shifted_c;
        load_err_c  = 1'b0;
        if (clr) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (bit_en) begin
            unique case (state_q)
                IDLE, SHIFT: begin
                    order_d = order_c;
                    shreg_d = shifted_c;
                    if (cnt_q == LAST_CNT) begin
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
                        cnt_d   = cnt_q + CW'(1);
`else
                        state_d = IDLE;
                        cnt_d   = '0;
                        load_c  = 1'b1;
`endif
                    end else begin
                        state_d = SHIFT;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    load_c      = 1'b1;
                    load_word_c = shreg_q;
                    load_err_c  = ((^shreg_q) ^ serial_in) != ODD_PARITY;
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            order_q <= ORDER_LSB;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
        end
    end

`ifndef PARITY_CHECK_EN
    logic unused_odd_c;
    assign unused_odd_c = ODD_PARITY;
`endif

    sipo_word_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load_c),
        .data_i    (load_word_c),
        .err_i     (load_err_c),
        .ready_i   (word_ready),
        .data_o    (word_out),
        .valid_o   (word_valid),
        .err_o     (parity_err),
        .overrun_o (overrun)
    );

    assign bit_count = cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: expected words are queued at stimulus time, a monitor checks each pop.
module tb_sipo_deser;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 2);
`ifdef PARITY_CHECK_EN
    localparam int unsigned FB = W + 1;
`else
    localparam int unsigned FB = W;
`endif
    localparam logic ODD = 1'b0;

    typedef struct packed {
        logic [W-1:0] w;
        logic         perr;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          bit_en;
    logic          serial_in;
    logic          msb_first;
    logic          clr;
    logic [W-1:0]  word_out;
    logic          word_valid;
    logic          word_ready;
    logic          overrun;
    logic [CW-1:0] bit_count;
    logic          parity_err;

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   ovr_cnt = 0;
    bit   lat_chk = 1'b0;

    sipo_deser #(
        .WIDTH      (W),
        .ODD_PARITY (ODD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .msb_first  (msb_first),
        .clr        (clr),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overrun    (overrun),
        .bit_count  (bit_count),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake pops one expected word.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (overrun) ovr_cnt++;
            if (word_valid && word_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", word_out);
                end else begin
                    e = q.pop_front();
                    chk("sb_word_out", 64'(word_out), 64'(e.w));
                    chk("sb_parity_err", 64'(parity_err), 64'(e.perr));
                end
            end
        end
    end

    task automatic send_word(input logic [W-1:0] w, input logic msb, input int gap,
                             input bit flip, input bit pop_last, input bit bad_par, input bit push);
        exp_t e;
        if (push) begin
            e.w = w;
`ifdef PARITY_CHECK_EN
            e.perr = bad_par;
`else
            e.perr = 1'b0;
`endif
            q.push_back(e);
        end
        for (int i = 0; i < int'(FB); i++) begin
            bit_en = 1'b1;
            if (i < int'(W)) serial_in = msb ? w[W-1-i] : w[i];
            else             serial_in = (^w) ^ ODD ^ bad_par;
            msb_first = (flip && i >= 4) ? ~msb : msb;
            if (pop_last && i == int'(FB) - 1) word_ready = 1'b1;
            if (lat_chk && i == int'(FB) - 1) chk("valid_before_last", 64'(word_valid), 64'(0));
            tick();
            bit_en    = 1'b0;
            serial_in = 1'b0;
            chk("bit_count", 64'(bit_count), (i == int'(FB) - 1) ? 64'(0) : 64'(i + 1));
            if (lat_chk && i == int'(FB) - 1) begin
                chk("valid_after_last", 64'(word_valid), 64'(1));
                chk("overrun_quiet", 64'(overrun), 64'(0));
            end
            repeat (gap) tick();
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst_n      = 1'b0;
        bit_en     = 1'b0;
        serial_in  = 1'b0;
        msb_first  = 1'b1;
        clr        = 1'b0;
        word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word_out", 64'(word_out), 64'(0));
        chk("rst_word_valid", 64'(word_valid), 64'(0));
        chk("rst_bit_count", 64'(bit_count), 64'(0));
        chk("rst_overrun", 64'(overrun), 64'(0));
        chk("rst_parity_err", 64'(parity_err), 64'(0));
        rst_n = 1'b1;
        tick();

        // MSB order, back-to-back bits, latency checked on the final bit
        lat_chk = 1'b1;
        send_word(8'hA5, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        lat_chk = 1'b0;
        tick();

        // LSB order
        send_word(8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h0F, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // Sparse strobes with msb_first flipped mid-frame
        send_word(8'hA5, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();

        // Stalled consumer: second word overruns, third lands in the pop cycle
        word_ready = 1'b0;
        send_word(8'h3C, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'hC3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("overrun_pulse", 64'(overrun), 64'(1));
        chk("held_word", 64'(word_out), 64'(8'h3C));
        tick();
        chk("overrun_one_cycle", 64'(overrun), 64'(0));
        chk("overrun_count", 64'(ovr_cnt), 64'(1));
        send_word(8'h81, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("no_bubble_valid", 64'(word_valid), 64'(1));
        chk("no_bubble_word", 64'(word_out), 64'(8'h81));
        tick();

        // clr with a simultaneous bit aborts the frame; buffered word survives
        word_ready = 1'b0;
        send_word(8'h5A, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bit_en    = 1'b1;
            serial_in = i[0];
            tick();
        end
        bit_en = 1'b0;
        chk("partial_count", 64'(bit_count), 64'(5));
        bit_en    = 1'b1;
        serial_in = 1'b1;
        clr       = 1'b1;
        tick();
        bit_en = 1'b0;
        clr    = 1'b0;
        chk("clr_count", 64'(bit_count), 64'(0));
        chk("clr_keeps_valid", 64'(word_valid), 64'(1));
        chk("clr_keeps_word", 64'(word_out), 64'(8'h5A));
        word_ready = 1'b1;
        send_word(8'h96, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

`ifdef PARITY_CHECK_EN
        send_word(8'h07, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        send_word(8'h07, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("perr_set", 64'(parity_err), 64'(1));
        chk("perr_word_delivered", 64'(word_valid), 64'(1));
        tick();
`endif

        // Asynchronous reset mid-frame with a word buffered
        word_ready = 1'b0;
        send_word(8'hE7, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bit_en    = 1'b1;
            serial_in = 1'b1;
            tick();
        end
        bit_en = 1'b0;
        chk("pre_reset_valid", 64'(word_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_word_out", 64'(word_out), 64'(0));
        chk("arst_word_valid", 64'(word_valid), 64'(0));
        chk("arst_bit_count", 64'(bit_count), 64'(0));
        chk("arst_overrun", 64'(overrun), 64'(0));
        chk("arst_parity_err", 64'(parity_err), 64'(0));
        word_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        send_word(8'h3A, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (3) tick();
        chk("scoreboard_drained", 64'(q.size()), 64'(0));
        chk("overrun_total", 64'(ovr_cnt), 64'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
